// File: rtl/bl_pkg.sv
// bl_pkg: shared defaults, index widths and FSM states for the backlight block-max path
package bl_pkg;
  localparam int BL_DW = 8;
  localparam int BL_NBLK_H = 8;
  localparam int BL_NBLK_V = 4;
  localparam int BL_COL_W = $clog2(BL_NBLK_H);
  localparam int BL_ROW_W = $clog2(BL_NBLK_V);
  typedef enum logic {IDLE, DRAIN} blState;
endpackage

// File: rtl/block_max_grid.sv
// block_max_grid: reduces per-line segment maxima into column maxima per block row and drains them via valid/ready
module block_max_grid
  import bl_pkg::*;
#(
  parameter int NBLK_H = BL_NBLK_H,
  parameter int NBLK_V = BL_NBLK_V,
  parameter int DW = BL_DW
) (
  input  logic                      iODCK,
  input  logic                      iRST,
  input  logic                      iV_Duty,
  input  logic                      iH_Duty,
  input  logic [DW-1:0]             iBlockData,
  input  logic                      iReady,
  output logic                      oValid,
  output logic [DW-1:0]             oData,
  output logic [$clog2(NBLK_H)-1:0] oCol,
  output logic [$clog2(NBLK_V)-1:0] oRow,
  output logic                      oLast,
  output logic                      oOverrun
);
  localparam int CW = $clog2(NBLK_H);
  localparam int RW = $clog2(NBLK_V);
  localparam logic [CW-1:0] LAST_COL = CW'(NBLK_H - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NBLK_V - 1);
  logic hPrev, vPrev, strobe, rowEnd, load;
  logic [CW-1:0] segCnt, rd, rdNext;
  logic [RW-1:0] rowCnt, rowIdx;
  logic [DW-1:0] acc [NBLK_H];
  logic [DW-1:0] snap [NBLK_H];
  logic [DW-1:0] shadow [NBLK_H];
  blState state, stateNext;
  assign rowEnd = vPrev & ~iV_Duty;
  // snap folds in a strobe landing in the row-end cycle so it reaches the shadow
  always_comb begin
    for (int i = 0; i < NBLK_H; i++)
      snap[i] = (strobe && segCnt == CW'(i) && iBlockData > acc[i]) ? iBlockData : acc[i];
  end
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      hPrev <= 1'b0;
      vPrev <= 1'b0;
      strobe <= 1'b0;
      segCnt <= '0;
      rowCnt <= '0;
      for (int i = 0; i < NBLK_H; i++) acc[i] <= '0;
    end else begin
      hPrev <= iH_Duty;
      vPrev <= iV_Duty;
      strobe <= iV_Duty & ~iH_Duty & hPrev;
      if (rowEnd || (!iV_Duty && !strobe)) begin
        segCnt <= '0;
        for (int i = 0; i < NBLK_H; i++) acc[i] <= '0;
      end else if (strobe) begin
        segCnt <= (segCnt == LAST_COL) ? '0 : segCnt + 1'b1;
        acc <= snap;
      end
      if (rowEnd) rowCnt <= (rowCnt == LAST_ROW) ? '0 : rowCnt + 1'b1;
    end
  end
  always_comb begin
    stateNext = state;
    rdNext = rd;
    load = 1'b0;
    if (state == IDLE) begin
      stateNext = rowEnd ? DRAIN : IDLE;
      load = rowEnd;
      rdNext = '0;
    end else if (iReady) begin
      if (rd == LAST_COL) begin
        stateNext = rowEnd ? DRAIN : IDLE;
        load = rowEnd;
        rdNext = '0;
      end else begin
        rdNext = rd + 1'b1;
      end
    end
  end
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      state <= IDLE;
      rd <= '0;
      rowIdx <= '0;
      oOverrun <= 1'b0;
      for (int i = 0; i < NBLK_H; i++) shadow[i] <= '0;
    end else begin
      state <= stateNext;
      rd <= rdNext;
      oOverrun <= rowEnd & ~load;
      if (load) begin
        shadow <= snap;
        rowIdx <= rowCnt;
      end
    end
  end
  assign oValid = (state == DRAIN);
  assign oData = oValid ? shadow[rd] : '0;
  assign oCol = rd;
  assign oRow = oValid ? rowIdx : '0;
  assign oLast = oValid & (rd == LAST_COL);
endmodule

// File: tb/tb_block_max_grid.sv
// tb_block_max_grid: directed checks of row reduction, drain handshake, overrun and reset
module tb_block_max_grid;
  logic iODCK = 1'b0;
  logic iRST = 1'b0;
  logic iV_Duty = 1'b0;
  logic iH_Duty = 1'b0;
  logic [7:0] iBlockData = '0;
  logic iReady = 1'b0;
  logic oValid, oLast, oOverrun;
  logic [7:0] oData;
  logic [1:0] oCol;
  logic oRow;
  int errors = 0;
  int checks = 0;
  logic [7:0] bpData [4] = '{8'd7, 8'd8, 8'd9, 8'd6};
  logic bpReady [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};

  block_max_grid #(.NBLK_H(4), .NBLK_V(2), .DW(8)) dut (
    .iODCK(iODCK), .iRST(iRST), .iV_Duty(iV_Duty), .iH_Duty(iH_Duty),
    .iBlockData(iBlockData), .iReady(iReady), .oValid(oValid), .oData(oData),
    .oCol(oCol), .oRow(oRow), .oLast(oLast), .oOverrun(oOverrun)
  );

  always #5 iODCK = ~iODCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iODCK);
    #1;
  endtask

  task automatic seg(input logic [7:0] d);
    iBlockData = d;
    iH_Duty = 1'b1;
    tick();
    tick();
    iH_Duty = 1'b0;
    tick();
    tick();
  endtask

  // last segment whose strobe lands in the row-end cycle; returns positioned in that cycle
  task automatic segEnd(input logic [7:0] d);
    iBlockData = d;
    iH_Duty = 1'b1;
    tick();
    tick();
    iH_Duty = 1'b0;
    tick();
    iV_Duty = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [7:0] d, input int col, input int row, input logic last);
    check({tag, ".valid"}, oValid, 1);
    check({tag, ".data"}, oData, d);
    check({tag, ".col"}, oCol, col);
    check({tag, ".row"}, oRow, row);
    check({tag, ".last"}, oLast, last);
    tick();
  endtask

  initial begin
    int k;
    repeat (3) tick();
    iRST = 1'b1;
    tick();
    check("rst.valid", oValid, 0);
    check("rst.data", oData, 0);
    check("rst.col", oCol, 0);
    check("rst.row", oRow, 0);
    check("rst.last", oLast, 0);
    check("rst.ovr", oOverrun, 0);

    iReady = 1'b1;
    iV_Duty = 1'b1;
    tick();
    seg(10); seg(20); seg(30); seg(40);
    seg(50); seg(5); seg(35); seg(1);
    iV_Duty = 1'b0;
    check("r0.validAtT", oValid, 0);
    tick();
    xfer("r0c0", 50, 0, 0, 0);
    xfer("r0c1", 20, 1, 0, 0);
    xfer("r0c2", 35, 2, 0, 0);
    xfer("r0c3", 40, 3, 0, 1);
    check("r0.done", oValid, 0);

    iReady = 1'b0;
    iV_Duty = 1'b1;
    tick();
    seg(7); seg(8); seg(9); seg(6);
    iV_Duty = 1'b0;
    tick();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      iReady = bpReady[c];
      check("bp.valid", oValid, k < 4);
      if (k < 4) begin
        check("bp.data", oData, bpData[k]);
        check("bp.col", oCol, k);
        check("bp.row", oRow, 1);
      end
      tick();
      if (bpReady[c] && k < 4) k++;
    end
    check("bp.count", k, 4);
    check("bp.done", oValid, 0);

    iReady = 1'b0;
    iV_Duty = 1'b1;
    tick();
    seg(100); seg(101); seg(102); seg(103);
    iV_Duty = 1'b0;
    iReady = 1'b1;
    tick();
    tick();
    tick();
    iReady = 1'b0;
    check("ov.stallCol", oCol, 2);
    iV_Duty = 1'b1;
    tick();
    seg(200); seg(200); seg(200); seg(200);
    iV_Duty = 1'b0;
    check("ov.preT", oOverrun, 0);
    tick();
    check("ov.pulse", oOverrun, 1);
    check("ov.holdData", oData, 102);
    check("ov.holdCol", oCol, 2);
    check("ov.holdRow", oRow, 0);
    tick();
    check("ov.once", oOverrun, 0);
    iReady = 1'b1;
    xfer("ov.c2", 102, 2, 0, 0);
    xfer("ov.c3", 103, 3, 0, 1);
    for (int c = 0; c < 4; c++) check("ov.dropped", oValid, 0);
    tick();
    check("ov.dropped2", oValid, 0);

    iV_Duty = 1'b1;
    tick();
    seg(60);
    segEnd(70);
    tick();
    xfer("r4c0", 60, 0, 0, 0);
    xfer("r4c1", 70, 1, 0, 0);
    xfer("r4c2", 0, 2, 0, 0);
    iReady = 1'b0;
    check("r4c3.data", oData, 0);
    check("r4c3.last", oLast, 1);
    iV_Duty = 1'b1;
    tick();
    seg(11); seg(22); seg(33); seg(44);
    iV_Duty = 1'b0;
    iReady = 1'b1;
    check("same.lastAtT", oLast, 1);
    check("same.colAtT", oCol, 3);
    tick();
    check("same.noOvr", oOverrun, 0);
    xfer("r5c0", 11, 0, 1, 0);
    check("r5c1.data", oData, 22);
    #2 iRST = 1'b0;
    #1;
    check("mrst.valid", oValid, 0);
    check("mrst.data", oData, 0);
    check("mrst.col", oCol, 0);
    check("mrst.row", oRow, 0);
    check("mrst.last", oLast, 0);
    check("mrst.ovr", oOverrun, 0);
    tick();
    iRST = 1'b1;
    tick();
    check("mrst.idle", oValid, 0);

    iV_Duty = 1'b1;
    tick();
    seg(3); seg(4); seg(5); seg(6);
    iV_Duty = 1'b0;
    tick();
    check("r7.noOvr", oOverrun, 0);
    xfer("r7c0", 3, 0, 0, 0);
    xfer("r7c1", 4, 1, 0, 0);
    xfer("r7c2", 5, 2, 0, 0);
    xfer("r7c3", 6, 3, 0, 1);
    check("r7.done", oValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/block_max_grid.md
# block_max_grid

Downstream stage of the per-block maximum extractor in the dynamic backlight dimming path. Collects the 8-bit segment maxima produced during each block row (iV_Duty window) into per-column accumulators and reduces them across lines. At the end of the row it snapshots the column maxima into a shadow buffer and streams them out with a valid/ready handshake to the backlight duty/LUT stage. Acquisition of the next row overlaps the drain.

## Interface
- NBLK_H, 8: block columns per row (segments per line); ≥2
- NBLK_V, 4: block rows per frame; ≥2
- DW, 8: data width
- iODCK  in  1  pixel clock, all logic on rising edge
- iRST  in  1  reset; asynchronous, active-low
- iV_Duty  in  1  block-row window, high for all lines of a block row
- iH_Duty  in  1  segment window, high during active pixels of a segment
- iBlockData  in  DW  segment maximum from the upstream max stage
- iReady  in  1  consumer ready
- oValid  out  1  oData/oCol/oRow/oLast valid
- oData  out  DW  column maximum of the finished block row
- oCol  out  $clog2(NBLK_H)  column index of oData
- oRow  out  $clog2(NBLK_V)  row index of oData
- oLast  out  1  high with column NBLK_H-1
- oOverrun  out  1  one-cycle pulse, finished row dropped

## Operation
- Capture strobe: cycle N has iV_Duty=1, iH_Duty=0 and iH_Duty=1 in cycle N-1. Strobe fires in cycle N+1; iBlockData is sampled in N+1 regardless of iV_Duty in N+1.
- seg_cnt: on each strobe, acc[seg_cnt] <= max(acc[seg_cnt], iBlockData) (unsigned); seg_cnt wraps NBLK_H-1 -> 0, giving the line boundary.
- While iV_Duty=0 with no strobe: all acc cleared to 0, seg_cnt = 0.
- Row end: first cycle with iV_Duty=0 after iV_Duty=1 (cycle T).
  - Snapshot = acc including any strobe applied in T.
  - acc clears from T+1.
  - row_cnt increments, wrapping NBLK_V-1 -> 0. It increments even when the row is dropped.
- FSM IDLE/DRAIN:
  - IDLE + row end -> load shadow, latch row index, rd=0, DRAIN.
  - DRAIN: oValid=1, oData=shadow[rd], oCol=rd, oLast=(rd==NBLK_H-1). On oValid&iReady: rd++. Transfer with oLast -> IDLE.
  - Row end while DRAIN: snapshot discarded, oOverrun pulses in T+1, drain continues unaffected.
  - Row end in the same cycle as the oLast transfer: accepted, no overrun. FSM stays in DRAIN with rd=0 and the new shadow.
- Outputs hold stable while oValid & !iReady.
- Columns never struck in a row output 0.
- Reset (asynchronous, any time, including mid-drain): oValid=0, oData=0, oCol=0, oRow=0, oLast=0, oOverrun=0. acc, shadow, seg_cnt, rd, row_cnt = 0. FSM = IDLE. In-flight row is lost.

## Timing
- Strobe 1 cycle after the first iH_Duty-low cycle, i.e. 2 cycles after the H fall edge.
- oValid rises in T+1. Column k transfers no earlier than T+1+k; full drain is NBLK_H cycles with iReady held high.
- oOverrun is registered, in T+1.
- No combinational path from iReady to oValid.

## Structure
- Shared package `bl_pkg`:
  - DW default, NBLK_H/NBLK_V defaults
  - FSM state enum {IDLE, DRAIN}
  - index width localparams
- Single module. No sub-module is needed; the acc and shadow arrays are flat register arrays (NBLK_H×DW each).

## Test plan
- Reset check (NBLK_H=4, NBLK_V=2, DW=8): release reset with iV_Duty=0 -> all outputs 0, no oValid.
- Single row, 2 lines of 4 segments:
  - Line 1 data 10,20,30,40; line 2 data 50,5,35,1, each sampled 2 cycles after the H fall.
  - Required response: after the V fall, 4 transfers (data,col) = (50,0),(20,1),(35,2),(40,3), oRow=0, oLast on col 3, first oValid at T+1.
- Backpressure:
  - Hold iReady=0 for 5 cycles, then toggle 1/0.
  - Required response: data stable while stalled, order preserved, no duplicates.
- Overrun:
  - Next row ends while 2 columns are still pending.
  - Required response: oOverrun pulses once; the old row completes; the new row is not emitted; the following row reports oRow=0 (wrap after rows 0,1).
- Boundary cases:
  - V fall in the same cycle as the oLast handshake -> new row accepted, no overrun.
  - Strobe in cycle T -> its data is included in the snapshot.
  - Row with only 2 segments -> cols 2,3 output 0.
- Mid-drain reset: assert iRST at col 1 -> outputs 0 at once; after release, the next row drains cleanly from col 0, row 0.
